// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for the MAC datapath: wide accumulate, bias, one round-half-up step.
// Define MAC_SAT_EN to saturate the rounded result to the output width instead of wrapping.
module mac_seq_ctrl #(
  parameter int unsigned INPUT_DATA_WIDTH  = 8,
  parameter int unsigned OUTPUT_DATA_WIDTH = 8,
  parameter int unsigned MAX_LEN           = 25,
  parameter int unsigned SHIFT             = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [$clog2(MAX_LEN+1)-1:0]      cfg_len,
  input  logic [INPUT_DATA_WIDTH-1:0]       bias_in,
  output logic                              busy,
  input  logic                              pair_valid,
  output logic                              pair_ready,
  input  logic [INPUT_DATA_WIDTH-1:0]       data_in,
  input  logic [INPUT_DATA_WIDTH-1:0]       weight_in,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0]      res_out
);

  localparam int unsigned IW = INPUT_DATA_WIDTH;
  localparam int unsigned OW = OUTPUT_DATA_WIDTH;
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = 2 * IW + $clog2(MAX_LEN) + 1;
  localparam int unsigned RW = AW + 1;
  localparam int unsigned QW = RW - SHIFT;

  localparam logic [LW-1:0] MaxLen  = LW'(MAX_LEN);
  localparam logic [RW-1:0] RndHalf = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StRnd, StOut} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   bias_q, bias_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [OW-1:0]   res_q, res_d;
  logic            busy_q, busy_d;
  logic            pair_ready_q, pair_ready_d;
  logic            res_valid_q, res_valid_d;

  logic [2*IW-1:0] prod;
  logic [LW-1:0]   len_clamp;
  logic [RW-1:0]   rnd_sum;
  logic [QW-1:0]   rnd_q;
  logic [OW-1:0]   rnd_res;
  logic            unused_rnd_lsb;

  assign prod      = {{IW{1'b0}}, data_in} * {{IW{1'b0}}, weight_in};
  assign len_clamp = (cfg_len > MaxLen) ? MaxLen : cfg_len;

  // Accumulator is sized so acc + bias + half never overflows RW bits.
  assign rnd_sum        = {1'b0, acc_q} + RW'(bias_q) + RndHalf;
  assign rnd_q          = rnd_sum[RW-1:SHIFT];
  assign unused_rnd_lsb = ^rnd_sum[SHIFT-1:0];

`ifdef MAC_SAT_EN
  assign rnd_res = (|rnd_q[QW-1:OW]) ? {OW{1'b1}} : rnd_q[OW-1:0];
`else
  logic unused_rnd_msb;
  assign unused_rnd_msb = ^rnd_q[QW-1:OW];
  assign rnd_res        = rnd_q[OW-1:0];
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    bias_d  = bias_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = len_clamp;
          bias_d  = bias_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (len_clamp == '0) ? StRnd : StAcc;
        end
      end
      StAcc: begin
        if (pair_valid && pair_ready_q) begin
          acc_d = acc_q + AW'(prod);
          cnt_d = cnt_q + LW'(1);
          if (cnt_d == len_q) begin
            state_d = StRnd;
          end
        end
      end
      StRnd: begin
        res_d   = rnd_res;
        state_d = StOut;
      end
      StOut: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Handshake outputs are registered from the next state.
    busy_d       = (state_d != StIdle);
    pair_ready_d = (state_d == StAcc);
    res_valid_d  = (state_d == StOut);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      len_q        <= '0;
      cnt_q        <= '0;
      bias_q       <= '0;
      acc_q        <= '0;
      res_q        <= '0;
      busy_q       <= 1'b0;
      pair_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      bias_q       <= bias_d;
      acc_q        <= acc_d;
      res_q        <= res_d;
      busy_q       <= busy_d;
      pair_ready_q <= pair_ready_d;
      res_valid_q  <= res_valid_d;
    end
  end

  assign busy       = busy_q;
  assign pair_ready = pair_ready_q;
  assign res_valid  = res_valid_q;
  assign res_out    = res_q;

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller for the LeNet MAC datapath: runs one dot product of runtime length (one convolution window or FC neuron) over a stream of data/weight pairs, adds the bias once, then rounds and optionally saturates to the output width. It sits between the feature/weight fetch logic and the output buffer, with valid/ready handshakes on both sides. It replaces per-tap combinational MAC-plus-round with a single wide accumulator and one rounding step per result.

## Interface
Parameters:
- INPUT_DATA_WIDTH, 8, width of data_in, weight_in, bias_in (all unsigned)
- OUTPUT_DATA_WIDTH, 8, width of res_out
- MAX_LEN, 25, maximum taps per dot product
- SHIFT, 4, fractional bits dropped by rounding (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  clock, rising edge
- rst_n  input  1  async active-low reset
- start  input  1  request a new dot product; accepted only in IDLE
- cfg_len  input  $clog2(MAX_LEN+1)  tap count, sampled at start
- bias_in  input  INPUT_DATA_WIDTH  bias, sampled at start
- busy  output  1  high in every state except IDLE
- pair_valid  input  1  data_in/weight_in valid
- pair_ready  output  1  high only in ACC
- data_in  input  INPUT_DATA_WIDTH  activation
- weight_in  input  INPUT_DATA_WIDTH  weight
- res_valid  output  1  res_out valid, high only in OUT
- res_ready  input  1  consumer accepts res_out
- res_out  output  OUTPUT_DATA_WIDTH  rounded result, registered

## Operation
- Accumulator acc width AW = 2*INPUT_DATA_WIDTH + $clog2(MAX_LEN) + 1, unsigned; cannot overflow for any legal len.
- States: IDLE, ACC, RND, OUT.
- IDLE: on start=1, latch len = min(cfg_len, MAX_LEN) and bias, clear acc and tap counter. Go to ACC if len≠0, otherwise to RND.
- ACC: pair_ready=1. On each pair_valid&pair_ready edge: acc += data_in*weight_in and the counter increments. The edge that accepts tap len goes to RND. pair_valid low stalls with no change.
- RND: one cycle. Compute r = (acc + bias + 2^(SHIFT-1)) >> SHIFT (round half up) and register res_out from r, then go to OUT.
- OUT: res_valid=1 and res_out is held stable. On res_valid&res_ready, go to IDLE.
- start outside IDLE is ignored (not queued). cfg_len and bias_in are ignored outside the start-accept cycle.

## Timing
- Reset: state=IDLE, acc=0, counter=0, res_out=0, busy=0, pair_ready=0, res_valid=0. Reset asserted mid-operation aborts immediately. The partial result is discarded and no res_valid is produced.
- start accepted at edge 0, which gives busy=1 and pair_ready=1 in the next cycle. With back-to-back pairs, tap k is accepted at edge k.
- The last pair is accepted at edge L, RND runs in cycle L+1, and res_valid rises after edge L+1. Latency from the last accepted pair to res_valid is 2 edges.
- len=0: start at edge 0, RND in cycle 1, res_valid after edge 1.
- After the result handshake, the block is in IDLE for at least one cycle before the next start is accepted. Minimum period is L+3 cycles.
- Backpressure: res_valid stays high and res_out stays unchanged for any number of cycles while res_ready=0.

## Configuration
- MAC_SAT_EN defined: if r ≥ 2^OUTPUT_DATA_WIDTH, res_out = 2^OUTPUT_DATA_WIDTH−1, otherwise r.
- MAC_SAT_EN undefined: res_out = r[OUTPUT_DATA_WIDTH-1:0] (wrap).
- Nothing else changes, including latency, handshakes and reset values.

## Test plan
All cases use defaults: INPUT_DATA_WIDTH=8, OUTPUT_DATA_WIDTH=8, MAX_LEN=25, SHIFT=4.
- Basic dot product: len=3, bias=5, pairs (10,20),(3,4),(255,1) sent back-to-back -> res_out=30 ((472+8)>>4), res_valid after edge 4.
- Full-length overflow: len=25, all pairs (255,255), bias=255 -> r=101618, res_out=255 with MAC_SAT_EN and 242 without.
- Zero length and rounding: len=0 with bias=40 -> res_out=3, res_valid after edge 1. len=1 with pair (3,8) and bias=0 -> res_out=2 (half rounds up).
- Stalls and backpressure: pair_valid toggled 1/0 every cycle -> same result as back-to-back, pairs accepted only on high cycles. Hold res_ready=0 for 5 cycles while pulsing start -> res_out stable, start ignored, IDLE reached the cycle after res_ready=1.
- Clamping: cfg_len=31 -> exactly 25 pairs accepted (pair_ready low after the 25th), then result.
- Reset mid-ACC: rst_n low after 2 of 5 taps -> all outputs 0 immediately. A new start with len=1 and pair (16,1), bias 0 -> res_out=1 with no residue from the aborted run.
